// File: rtl/pixel_pkg.sv
// Shared pixel/screen definitions for the blitter and its neighbours.
//   SCR_W / SCR_H : visible screen size in pixels
//   PIX_COL_W     : default colour depth, colour_t : matching colour type
//   mode_t        : blit mode encodings (copy / colour-key / fill)
package pixel_pkg;

    localparam int SCR_W     = 160;
    localparam int SCR_H     = 120;
    localparam int PIX_COL_W = 3;

    typedef logic [PIX_COL_W-1:0] colour_t;

    typedef enum logic [1:0] {
        MODE_COPY = 2'b00,
        MODE_KEY  = 2'b01,
        MODE_FILL = 2'b10
    } mode_t;

endpackage

// File: rtl/blit_scan_counter.sv
// Raster scan counter for the image blitter.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : restart the scan at (0,0), address 0
//   advance     : step to the next pixel (row-major)
//   col, row    : current image column / row
//   addr        : current ROM address (row * IMG_W + col)
//   last        : current address is the final pixel of the image
module blit_scan_counter #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance,
    output logic [7:0]        col,
    output logic [6:0]        row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    import pixel_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [7:0]        LAST_COL  = 8'(IMG_W - 1);

    assign last = (addr == LAST_ADDR);

    // The address is kept as its own counter so no multiplier is needed;
    // it stops on the last pixel rather than running past the image.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance && !last) begin
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_blitter.sv
// Image blitter: copies an IMG_W x IMG_H image from a synchronous ROM to the
// VGA adapter pixel-write port at origin (x0, y0), with copy, colour-key and
// solid-fill modes and off-screen clipping.
//   clk, resetn          : clock, synchronous active-low reset
//   start                : blit request (sampled only when idle)
//   x0, y0               : origin, latched on accepted start
//   mode                 : 00 copy, 01 colour-key, 10 fill, 11 copy
//   key_col, fill_col    : transparent colour / fill colour
//   rom_addr, rom_q      : image ROM address and data (ROM_LAT latency)
//   x_out, y_out, col_out, plot : pixel write to the VGA adapter
//   busy, done           : busy from accept through done; done one-cycle pulse
module image_blitter #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int COL_W   = 3,
    parameter int SCR_W   = pixel_pkg::SCR_W,
    parameter int SCR_H   = pixel_pkg::SCR_H,
    parameter int ROM_LAT = 1,
    parameter int ADDR_W  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        x0,
    input  logic [6:0]        y0,
    input  logic [1:0]        mode,
    input  logic [COL_W-1:0]  key_col,
    input  logic [COL_W-1:0]  fill_col,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [COL_W-1:0]  rom_q,
    output logic [7:0]        x_out,
    output logic [6:0]        y_out,
    output logic [COL_W-1:0]  col_out,
    output logic              plot,
    output logic              busy,
    output logic              done
);
    import pixel_pkg::*;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DW = $clog2(ROM_LAT + 2);

    state_t            state, state_next;
    logic              accept, issue;
    logic [DW-1:0]     drain_cnt;

    logic [7:0]        x0_r;
    logic [6:0]        y0_r;
    mode_t             mode_r;
    logic [COL_W-1:0]  key_r, fill_r;

    logic [7:0]        col;
    logic [6:0]        row;
    logic              last;

    logic [8:0]        sum_x;
    logic [7:0]        sum_y;
    logic              on_screen;

    logic              pipe_live [ROM_LAT];
    logic [7:0]        pipe_x    [ROM_LAT];
    logic [6:0]        pipe_y    [ROM_LAT];

    logic              key_hit, plot_next;

    blit_scan_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (accept),
        .advance (issue),
        .col     (col),
        .row     (row),
        .addr    (rom_addr),
        .last    (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DW'(ROM_LAT)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accept = (state == IDLE) && start;
        issue  = (state == RUN);
        busy   = (state != IDLE);
        done   = (state == DONE);
    end

    // DRAIN lasts ROM_LAT+1 cycles: counts 0..ROM_LAT
    always_ff @(posedge clk) begin
        if (!resetn || state != DRAIN) drain_cnt <= '0;
        else                           drain_cnt <= drain_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x0_r   <= '0;
            y0_r   <= '0;
            mode_r <= MODE_COPY;
            key_r  <= '0;
            fill_r <= '0;
        end else if (accept) begin
            x0_r   <= x0;
            y0_r   <= y0;
            key_r  <= key_col;
            fill_r <= fill_col;
            case (mode)
                2'b01:   mode_r <= MODE_KEY;
                2'b10:   mode_r <= MODE_FILL;
                default: mode_r <= MODE_COPY;
            endcase
        end
    end

    // Sums are one bit wider than the screen coordinates so a carry-out
    // counts as off-screen instead of wrapping back onto the screen.
    always_comb begin
        sum_x     = {1'b0, x0_r} + {1'b0, col};
        sum_y     = {1'b0, y0_r} + {1'b0, row};
        on_screen = (int'(sum_x) < SCR_W) && (int'(sum_y) < SCR_H);
    end

    // Clipping is folded into the valid bit at issue time.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) pipe_live[i] <= 1'b0;
        end else begin
            pipe_live[0] <= issue && on_screen;
            for (int unsigned i = 1; i < ROM_LAT; i++) pipe_live[i] <= pipe_live[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_x[0] <= sum_x[7:0];
        pipe_y[0] <= sum_y[6:0];
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end

    always_comb begin
        key_hit   = (mode_r == MODE_KEY) && (rom_q == key_r);
        plot_next = pipe_live[ROM_LAT-1] && !key_hit;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            plot    <= 1'b0;
            x_out   <= '0;
            y_out   <= '0;
            col_out <= '0;
        end else begin
            plot <= plot_next;
            if (plot_next) begin
                x_out   <= pipe_x[ROM_LAT-1];
                y_out   <= pipe_y[ROM_LAT-1];
                col_out <= (mode_r == MODE_FILL) ? fill_r : rom_q;
            end
        end
    end

endmodule

// File: tb/tb_image_blitter.sv
// Directed bench for image_blitter: two 4x2 instances (ROM latency 1 and 2)
// fed by ROM models whose contents equal the address (0..7).
module tb_image_blitter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [1:0] mode = '0;
    logic [2:0] key_col = '0, fill_col = '0;

    logic [2:0] addr1, addr2, q1, q2a, q2b;
    logic [7:0] xo1, xo2;
    logic [6:0] yo1, yo2;
    logic [2:0] co1, co2;
    logic       plot1, plot2, busy1, busy2, done1, done2;

    int vectors = 0;
    int miscompares = 0;
    bit sel = 1'b0;

    logic [2:0] o_addr, o_col;
    logic [7:0] o_x;
    logic [6:0] o_y;
    logic       o_plot, o_busy, o_done;

    always #5 clk = ~clk;

    image_blitter #(.IMG_W(4), .IMG_H(2), .COL_W(3), .SCR_W(160), .SCR_H(120), .ROM_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .x0(x0), .y0(y0), .mode(mode),
        .key_col(key_col), .fill_col(fill_col), .rom_addr(addr1), .rom_q(q1),
        .x_out(xo1), .y_out(yo1), .col_out(co1), .plot(plot1), .busy(busy1), .done(done1)
    );

    image_blitter #(.IMG_W(4), .IMG_H(2), .COL_W(3), .SCR_W(160), .SCR_H(120), .ROM_LAT(2)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .x0(x0), .y0(y0), .mode(mode),
        .key_col(key_col), .fill_col(fill_col), .rom_addr(addr2), .rom_q(q2b),
        .x_out(xo2), .y_out(yo2), .col_out(co2), .plot(plot2), .busy(busy2), .done(done2)
    );

    // ROM contents: word n holds colour n
    always @(posedge clk) begin
        q1  <= addr1;
        q2a <= addr2;
        q2b <= q2a;
    end

    assign o_addr = sel ? addr2 : addr1;
    assign o_x    = sel ? xo2   : xo1;
    assign o_y    = sel ? yo2   : yo1;
    assign o_col  = sel ? co2   : co1;
    assign o_plot = sel ? plot2 : plot1;
    assign o_busy = sel ? busy2 : busy1;
    assign o_done = sel ? done2 : done1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".plot"}, 32'(o_plot), 0);
        check({tag, ".busy"}, 32'(o_busy), 0);
        check({tag, ".done"}, 32'(o_done), 0);
        check({tag, ".x"},    32'(o_x),    0);
        check({tag, ".y"},    32'(o_y),    0);
        check({tag, ".col"},  32'(o_col),  0);
        check({tag, ".addr"}, 32'(o_addr), 0);
    endtask

    // Start one blit in cycle 0, then check every cycle through the first
    // idle cycle after done. Pixel n is expected on the outputs in cycle
    // 2+n+lat.
    task automatic run_blit(input string tag, input bit use2,
                            input logic [7:0] bx, input logic [6:0] by,
                            input logic [1:0] bm, input logic [2:0] bk, input logic [2:0] bf,
                            input int lat, input int exp_done, input int exp_plots);
        int n, ex, ey, nplots;
        bit ep;
        nplots = 0;
        sel = use2;
        @(negedge clk);
        x0 = bx; y0 = by; mode = bm; key_col = bk; fill_col = bf;
        if (use2) start2 = 1'b1; else start1 = 1'b1;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            n  = c - 2 - lat;
            ex = int'(bx) + (n % 4);
            ey = int'(by) + (n / 4);
            ep = (n >= 0) && (n < 8) && !(bm == 2'b01 && n == int'(bk)) && (ex < 160) && (ey < 120);
            if (c <= 8) check({tag, ".addr"}, 32'(o_addr), 32'(c - 1));
            check({tag, ".plot"}, 32'(o_plot), 32'(ep));
            if (ep && o_plot) begin
                nplots++;
                check({tag, ".x"},   32'(o_x),   32'(ex));
                check({tag, ".y"},   32'(o_y),   32'(ey));
                check({tag, ".col"}, 32'(o_col), (bm == 2'b10) ? 32'(bf) : 32'(n));
            end
            check({tag, ".done"}, 32'(o_done), 32'(c == exp_done));
            check({tag, ".busy"}, 32'(o_busy), 32'(c <= exp_done));
        end
        check({tag, ".nplots"}, 32'(nplots), 32'(exp_plots));
    endtask

    initial begin
        int np;

        // Reset state
        repeat (3) @(negedge clk);
        sel = 1'b0; check_zero("rst1");
        sel = 1'b1; check_zero("rst2");
        resetn = 1'b1;
        @(negedge clk);

        // Opaque copy at (10,20): 8 plots, done at cycle 11
        run_blit("copy", 1'b0, 8'd10, 7'd20, 2'b00, 3'd0, 3'd0, 1, 11, 8);
        // Colour key 3: pixel (13,20) skipped
        run_blit("key", 1'b0, 8'd10, 7'd20, 2'b01, 3'd3, 3'd0, 1, 11, 7);
        // Mode 11 behaves as copy
        run_blit("m11", 1'b0, 8'd10, 7'd20, 2'b11, 3'd3, 3'd0, 1, 11, 8);
        // Fill colour 5
        run_blit("fill", 1'b0, 8'd10, 7'd20, 2'b10, 3'd0, 3'd5, 1, 11, 8);
        // Bottom-right corner: only (158,119) and (159,119) survive clipping
        run_blit("clip", 1'b0, 8'd158, 7'd119, 2'b00, 3'd0, 3'd0, 1, 11, 2);
        // Carry-out of x and y must clip rather than wrap
        run_blit("wrap", 1'b0, 8'd254, 7'd126, 2'b00, 3'd0, 3'd0, 1, 11, 0);
        // Latency-2 instance
        run_blit("lat2", 1'b1, 8'd0, 7'd0, 2'b00, 3'd0, 3'd0, 2, 12, 8);

        // Reset mid-RUN, 3 cycles after start
        sel = 1'b0;
        @(negedge clk);
        x0 = 8'd10; y0 = 7'd20; mode = 2'b00;
        start1 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        check("mid.plot_before", 32'(o_plot), 1);
        resetn = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst.noplot", 32'(o_plot), 0);
            check("midrst.idle",   32'(o_busy), 0);
        end
        run_blit("after", 1'b0, 8'd30, 7'd40, 2'b00, 3'd0, 3'd0, 1, 11, 8);

        // start held for 20 cycles on the latency-2 instance: second blit
        // is accepted in the first idle cycle (13) and finishes at 25.
        sel = 1'b1;
        np = 0;
        @(negedge clk);
        x0 = 8'd10; y0 = 7'd20; mode = 2'b00;
        start2 = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            if (o_plot) np++;
            check("hold.done", 32'(o_done), 32'(c == 12 || c == 25));
            check("hold.busy", 32'(o_busy), 32'((c >= 1 && c <= 12) || (c >= 14 && c <= 25)));
            start2 = (c <= 19);
        end
        check("hold.nplots", 32'(np), 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
